// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_ERR   = 2'd2
    } pipe_state_e;

    // Register x0 is hardwired to zero, so a load targeting it never creates a hazard.
    function automatic logic load_use_hazard(
        input logic                  e_is_load,
        input logic [REG_ADDR_W-1:0] e_rd,
        input logic                  use_rs1,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic                  use_rs2,
        input logic [REG_ADDR_W-1:0] rs2
    );
        logic rs1_hit;
        logic rs2_hit;
        rs1_hit = use_rs1 && (rs1 == e_rd);
        rs2_hit = use_rs2 && (rs2 == e_rd);
        return e_is_load && (e_rd != '0) && (rs1_hit || rs2_hit);
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running stall/flush event counters; they wrap naturally at 2^CNT_W.
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: data-memory wait FSM with timeout, branch flush, load-use stall.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] D_rs1,
    input  logic [REG_ADDR_W-1:0] D_rs2,
    input  logic                  D_use_rs1,
    input  logic                  D_use_rs2,
    input  logic                  E_is_load,
    input  logic [REG_ADDR_W-1:0] E_rd,
    input  logic                  E_branch_taken,
    input  logic                  M_mem_req,
    input  logic                  dmem_ready,
    output logic                  stall_F,
    output logic                  stall_D,
    output logic                  stall_E,
    output logic                  stall_M,
    output logic                  flush_D,
    output logic                  flush_E,
    output logic                  flush_W,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    pipe_state_e       state;
    pipe_state_e       state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic              err_q;
    logic              err_next;
    logic              mem_stall;
    logic              load_use;

    assign load_use = load_use_hazard(E_is_load, E_rd, D_use_rs1, D_rs1, D_use_rs2, D_rs2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            err_q    <= err_next;
        end
    end

    // Once in MWAIT the held MEM instruction still owns the request, so only dmem_ready matters.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        err_next      = err_q;
        mem_stall     = 1'b0;
        stall_F       = 1'b0;
        stall_D       = 1'b0;
        stall_E       = 1'b0;
        stall_M       = 1'b0;
        flush_D       = 1'b0;
        flush_E       = 1'b0;
        flush_W       = 1'b0;

        case (state)
            ST_RUN: begin
                if (M_mem_req && !dmem_ready) begin
                    mem_stall     = 1'b1;
                    state_next    = ST_MWAIT;
                    wait_cnt_next = '0;
                end
            end
            ST_MWAIT: begin
                if (dmem_ready) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_next = ST_ERR;
                        err_next   = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt + 1'b1;
                    end
                end
            end
            ST_ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase

        // Priority: memory stall, then branch flush, then load-use; outputs are held low in reset.
        if (!rst) begin
            if (mem_stall) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                flush_W = 1'b1;
            end else if (E_branch_taken) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (load_use) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    assign mem_err = err_q;

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk      (clk),
        .rst      (rst),
        .stall_inc(stall_F),
        .flush_inc(flush_D | flush_E),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard/timeout/reset cases plus randomized traffic
// checked against a cycle-level behavioural model of pending memory accesses.
module tb_pipe_ctrl;

    localparam int TO = 8;
    localparam int CW = 8;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    D_rs1, D_rs2, E_rd;
    logic          D_use_rs1, D_use_rs2, E_is_load, E_branch_taken, M_mem_req, dmem_ready;
    logic          stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [7:0]    outs;

    int total = 0;
    int bad   = 0;

    // Model: an access is outstanding while a request has not seen dmem_ready.
    bit            mBusy;
    bit            mErr;
    int            mMiss;
    logic [CW-1:0] mStall;
    logic [CW-1:0] mFlush;

    pipe_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .D_rs1(D_rs1), .D_rs2(D_rs2), .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2),
        .E_is_load(E_is_load), .E_rd(E_rd), .E_branch_taken(E_branch_taken),
        .M_mem_req(M_mem_req), .dmem_ready(dmem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_err};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] expOut();
        logic [7:0] o;
        logic       haz;
        logic       memStall;
        o   = '0;
        haz = E_is_load && (E_rd != 5'd0) &&
              ((D_use_rs1 && D_rs1 == E_rd) || (D_use_rs2 && D_rs2 == E_rd));
        memStall = mErr || ((mBusy || M_mem_req) && !dmem_ready);
        if (memStall) begin
            o[7:4] = 4'hF;
            o[1]   = 1'b1;
        end else if (E_branch_taken) begin
            o[3] = 1'b1;
            o[2] = 1'b1;
        end else if (haz) begin
            o[7] = 1'b1;
            o[6] = 1'b1;
            o[2] = 1'b1;
        end
        o[0] = mErr;
        return o;
    endfunction

    task automatic modelReset();
        mBusy  = 1'b0;
        mErr   = 1'b0;
        mMiss  = 0;
        mStall = '0;
        mFlush = '0;
    endtask

    task automatic modelAdvance(input logic [7:0] o);
        if (o[7]) mStall = mStall + 1'b1;
        if (o[3] || o[2]) mFlush = mFlush + 1'b1;
        if (!mErr) begin
            if ((mBusy || M_mem_req) && !dmem_ready) begin
                mBusy = 1'b1;
                mMiss++;
                if (mMiss == TO + 1) mErr = 1'b1;
            end else begin
                mBusy = 1'b0;
                mMiss = 0;
            end
        end
    endtask

    task automatic checkCounters(input string tag);
        if (PERF) checkOutput(tag, {16'd0, stall_cnt, flush_cnt}, {16'd0, mStall, mFlush});
        else      checkOutput(tag, {16'd0, stall_cnt, flush_cnt}, 32'd0);
    endtask

    task automatic applyStimulus(input string tag,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic ld,
                                 input logic [4:0] rd, input logic br,
                                 input logic req, input logic rdy);
        logic [7:0] e;
        @(negedge clk);
        D_rs1 = rs1; D_rs2 = rs2; D_use_rs1 = u1; D_use_rs2 = u2;
        E_is_load = ld; E_rd = rd; E_branch_taken = br;
        M_mem_req = req; dmem_ready = rdy;
        #1;
        e = expOut();
        checkOutput(tag, {24'd0, outs}, {24'd0, e});
        checkCounters({tag, "_cnt"});
        modelAdvance(e);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Reset is raised mid-cycle with the current inputs still applied, so outputs must clear at once.
    task automatic doReset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput({tag, "_out"}, {24'd0, outs}, 32'd0);
        checkOutput({tag, "_cnt"}, {16'd0, stall_cnt, flush_cnt}, 32'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        D_rs1 = '0; D_rs2 = '0; D_use_rs1 = 1'b0; D_use_rs2 = 1'b0;
        E_is_load = 1'b0; E_rd = '0; E_branch_taken = 1'b0;
        M_mem_req = 1'b0; dmem_ready = 1'b1;
        rst = 1'b1;
        modelReset();
        doReset("reset0");
        idle("idle0");

        applyStimulus("loaduse", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        checkOutput("loaduse_const", {24'd0, outs}, 32'hC4);
        idle("loaduse_gone");
        applyStimulus("loaduse_x0", 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("loaduse_x0_const", {24'd0, outs}, 32'h00);

        for (int i = 0; i < 3; i++) begin
            applyStimulus("mwait", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            checkOutput("mwait_const", {24'd0, outs}, 32'hF2);
        end
        applyStimulus("mready", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("mready_const", {24'd0, outs}, 32'h00);
        idle("back_run");

        applyStimulus("all3", 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
        checkOutput("all3_const", {24'd0, outs}, 32'hF2);
        idle("all3_done");
        applyStimulus("br_lu", 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
        checkOutput("br_lu_const", {24'd0, outs}, 32'h0C);

        doReset("reset_to");
        for (int i = 0; i < TO + 1; i++) begin
            applyStimulus("to_wait", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("to_noerr_yet", {31'd0, mem_err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("to_err", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
            checkOutput("to_err_const", {24'd0, outs}, 32'hF3);
        end
        doReset("reset_err");
        idle("after_err");
        checkOutput("after_err_const", {24'd0, outs}, 32'h00);

        applyStimulus("mid_run", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus("mid_w1", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        doReset("reset_mid");
        idle("after_mid");

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                doReset("rnd_reset");
            end else begin
                applyStimulus("rnd",
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, the maximum number of data-memory wait cycles before the error state is entered.
REQ-002 SHALL have parameter CNT_W, default 32, the width of the performance counters.
REQ-003 SHALL have port clk, input, 1, clock, rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port D_rs1 / D_rs2, input, 5 each, source registers of the ID-stage instruction.
REQ-006 SHALL have port D_use_rs1 / D_use_rs2, input, 1 each, high when the ID-stage instruction reads that source.
REQ-007 SHALL have port E_is_load, input, 1, high when the EX-stage instruction is a load.
REQ-008 SHALL have port E_rd, input, 5, destination register of the EX-stage instruction.
REQ-009 SHALL have port E_branch_taken, input, 1, high when the EX-stage instruction redirects the PC.
REQ-010 SHALL have port M_mem_req, input, 1, high when the MEM-stage instruction accesses data memory.
REQ-011 SHALL have port dmem_ready, input, 1, high when data memory completes the access this cycle.
REQ-012 SHALL have ports stall_F, stall_D, stall_E, stall_M, output, 1 each, hold the IF, ID, EX and MEM pipeline registers.
REQ-013 SHALL have ports flush_D, flush_E, flush_W, output, 1 each, load a bubble into the ID, EX and WB registers.
REQ-014 SHALL have port mem_err, output, 1, sticky memory-timeout flag.
REQ-015 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each, performance counters.

Function
REQ-016 SHALL implement an FSM with three states: RUN, MWAIT and ERR.
REQ-017 In RUN with M_mem_req=1 and dmem_ready=0, SHALL assert stall_F/D/E/M and flush_W in the same cycle and go to MWAIT.
REQ-018 In RUN with M_mem_req=1 and dmem_ready=1, SHALL add no stall and stay in RUN.
REQ-019 In MWAIT with dmem_ready=0, SHALL assert stall_F/D/E/M and flush_W, and increment the wait counter.
REQ-020 In MWAIT with dmem_ready=1, SHALL deassert all stalls that cycle, clear the wait counter and go to RUN.
REQ-021 When the wait counter reaches TIMEOUT-1 with dmem_ready=0, SHALL go to ERR and set mem_err.
REQ-022 ERR SHALL hold all four stalls and flush_W asserted permanently until reset.
REQ-023 Load-use hazard = E_is_load AND E_rd≠0 AND ((D_use_rs1 AND D_rs1=E_rd) OR (D_use_rs2 AND D_rs2=E_rd)).
REQ-024 On a load-use hazard in RUN with no memory stall, SHALL assert stall_F, stall_D and flush_E for exactly that cycle.
REQ-025 On E_branch_taken in RUN with no memory stall, SHALL assert flush_D and flush_E.
REQ-026 Priority SHALL be memory stall (REQ-017/019/022) > branch flush > load-use; lower-priority hazards SHALL be ignored while a higher one is active.
REQ-027 stall/flush outputs SHALL be combinational from state and inputs; state and counters SHALL be registered.

Reset
REQ-028 On rst, SHALL set state to RUN, the wait counter to 0, mem_err to 0, and stall_cnt and flush_cnt to 0.
REQ-029 While rst is asserted, all stall and flush outputs SHALL be 0.
REQ-030 rst asserted in MWAIT or ERR SHALL abandon the wait immediately.

Configuration
REQ-031 With PIPE_CTRL_PERF_EN defined, stall_cnt SHALL increment on every cycle in which stall_F=1.
REQ-032 With PIPE_CTRL_PERF_EN defined, flush_cnt SHALL increment on every cycle in which flush_D or flush_E is 1.
REQ-033 With PIPE_CTRL_PERF_EN defined, both counters SHALL wrap at 2^CNT_W.
REQ-034 Without PIPE_CTRL_PERF_EN, stall_cnt and flush_cnt SHALL be constant 0, with no counter flops.

Structure
REQ-035 Package pipe_pkg SHALL hold the FSM state enum and REG_ADDR_W=5.
REQ-036 The optional counters SHALL be a sub-module pipe_perf_cnt, instantiated only under PIPE_CTRL_PERF_EN.

Verification
REQ-037 Load-use: E_is_load=1, E_rd=5, D_rs1=5, D_use_rs1=1 -> stall_F=stall_D=flush_E=1 for one cycle; the same with E_rd=0 -> all outputs 0.
REQ-038 Memory wait: M_mem_req=1, dmem_ready low for 3 cycles then high -> stalls high for 3 cycles, low on the ready cycle, state back to RUN.
REQ-039 Simultaneous events: branch taken plus load-use plus memory stall in one cycle -> only the memory stall outputs; with no memory stall, branch plus load-use -> flush_D=flush_E=1 and stall_F=0.
REQ-040 Timeout: TIMEOUT=8, dmem_ready held 0 -> ERR and mem_err=1 after 8 wait cycles; rst -> mem_err=0 and state RUN.
REQ-041 Reset mid-wait: rst pulsed at cycle 2 of MWAIT -> all outputs 0 immediately; PERF build -> stall_cnt=0 after reset.
